cpu_execute_stage: RTL and testbench

Execute stage of the in-order pipeline: the consuming (slave) end of the decode→execute bundle. It accepts one decoded instruction per handshake, resolves register operands through forwarding, runs the ALU (single-cycle ops plus a multi-cycle multiply), and holds the result, branch decision and commit/writeback control in a registered EX/MEM output stage for the commit stage.

---
 rtl/cpu_execute_stage.sv | 297 +++++++++++++++++++++++++++++
 tb/tb_cpu_execute_stage.sv | 229 ++++++++++++++++++++++
 2 files changed

// File: rtl/cpu_execute_stage.sv
// cpu_execute_stage
//   Execute stage of the in-order pipeline. Accepts one decoded instruction per
//   in_valid/in_ready handshake, resolves ra/rb through forwarding (own EX/MEM
//   register first, then the writeback stage), runs the ALU (single-cycle ops
//   plus a MUL_LATENCY-cycle multiply), and holds the result, branch decision
//   and commit/writeback controls in a registered output stage
//   (out_valid/out_ready) for the commit stage.
// Ports:
//   clk, rst_n (async, active low), flush (sync kill)
//   in_valid/in_ready, decoded controls, operands, register ids
//   fwd_wb_*  : writeback-stage forwarding source
//   out_*     : registered EX/MEM bundle with out_valid/out_ready handshake
module cpu_execute_stage #(
  parameter int REG_WIDTH          = 32,
  parameter int VIRTUAL_ADDR_WIDTH = 32,
  parameter int NUM_REGS           = 32,
  parameter int NUM_ALU_OPS        = 8,
  parameter int MUL_LATENCY        = 4
) (
  input  logic                            clk,
  input  logic                            rst_n,
  input  logic                            flush,
  input  logic                            in_valid,
  output logic                            in_ready,
  input  logic                            wb_mem_to_reg,
  input  logic                            wb_reg_write,
  input  logic                            cm_branch,
  input  logic                            cm_mem_write,
  input  logic                            cm_mem_read,
  input  logic [$clog2(NUM_ALU_OPS)-1:0]  ex_alu_op,
  input  logic                            ex_reg_b,
  input  logic [VIRTUAL_ADDR_WIDTH-1:0]   next_pc,
  input  logic [REG_WIDTH-1:0]            ra_data,
  input  logic [REG_WIDTH-1:0]            rb_data,
  input  logic [REG_WIDTH-1:0]            offset_data,
  input  logic [$clog2(NUM_REGS)-1:0]     ra_id,
  input  logic [$clog2(NUM_REGS)-1:0]     rb_id,
  input  logic [$clog2(NUM_REGS)-1:0]     reg_dest,
  input  logic                            use_reg_b,
  input  logic                            fwd_wb_valid,
  input  logic [$clog2(NUM_REGS)-1:0]     fwd_wb_dest,
  input  logic [REG_WIDTH-1:0]            fwd_wb_data,
  output logic                            out_valid,
  input  logic                            out_ready,
  output logic [REG_WIDTH-1:0]            out_alu_result,
  output logic [REG_WIDTH-1:0]            out_store_data,
  output logic [VIRTUAL_ADDR_WIDTH-1:0]   out_branch_target,
  output logic                            out_branch_taken,
  output logic [$clog2(NUM_REGS)-1:0]     out_reg_dest,
  output logic                            out_mem_to_reg,
  output logic                            out_reg_write,
  output logic                            out_mem_write,
  output logic                            out_mem_read
);

  localparam int RID  = $clog2(NUM_REGS);
  localparam int OPW  = $clog2(NUM_ALU_OPS);
  localparam int SHW  = $clog2(REG_WIDTH);
  localparam int CNTW = $clog2(MUL_LATENCY) + 1;

  localparam logic [OPW-1:0] OP_ADD = OPW'(0);
  localparam logic [OPW-1:0] OP_SUB = OPW'(1);
  localparam logic [OPW-1:0] OP_AND = OPW'(2);
  localparam logic [OPW-1:0] OP_OR  = OPW'(3);
  localparam logic [OPW-1:0] OP_XOR = OPW'(4);
  localparam logic [OPW-1:0] OP_SLL = OPW'(5);
  localparam logic [OPW-1:0] OP_SRL = OPW'(6);
  localparam logic [OPW-1:0] OP_MUL = OPW'(7);

  typedef enum logic [0:0] {ST_IDLE, ST_MUL_BUSY} state_t;

  state_t state_q, state_d;
  logic [CNTW-1:0] cnt_q, cnt_d;

  // Registered output bundle
  logic                          out_valid_q, out_valid_d;
  logic [REG_WIDTH-1:0]          out_alu_result_q, out_alu_result_d;
  logic [REG_WIDTH-1:0]          out_store_data_q, out_store_data_d;
  logic [VIRTUAL_ADDR_WIDTH-1:0] out_branch_target_q, out_branch_target_d;
  logic                          out_branch_taken_q, out_branch_taken_d;
  logic [RID-1:0]                out_reg_dest_q, out_reg_dest_d;
  logic                          out_mem_to_reg_q, out_mem_to_reg_d;
  logic                          out_reg_write_q, out_reg_write_d;
  logic                          out_mem_write_q, out_mem_write_d;
  logic                          out_mem_read_q, out_mem_read_d;

  // Multiply in flight: operands are resolved at accept so forwarding state
  // that changes during the busy window cannot corrupt them.
  logic [REG_WIDTH-1:0]          pend_a_q, pend_a_d;
  logic [REG_WIDTH-1:0]          pend_b_q, pend_b_d;
  logic [REG_WIDTH-1:0]          pend_store_q, pend_store_d;
  logic [VIRTUAL_ADDR_WIDTH-1:0] pend_target_q, pend_target_d;
  logic [RID-1:0]                pend_dest_q, pend_dest_d;
  logic                          pend_mem_to_reg_q, pend_mem_to_reg_d;
  logic                          pend_reg_write_q, pend_reg_write_d;
  logic                          pend_branch_q, pend_branch_d;
  logic                          pend_mem_write_q, pend_mem_write_d;
  logic                          pend_mem_read_q, pend_mem_read_d;

  logic                          accept, load_fast, load_mul, start_mul, out_free;
  logic                          own_ok;
  logic [REG_WIDTH-1:0]          fwd_a, fwd_b, op_a, op_b, alu_result, mul_result;
  logic [VIRTUAL_ADDR_WIDTH-1:0] fast_target;

  // Forwarding: own output register wins over writeback; id 0 never forwards.
  always_comb begin
    own_ok = out_valid_q && out_reg_write_q && !out_mem_to_reg_q;
    fwd_a  = ra_data;
    if (ra_id != '0) begin
      if (own_ok && out_reg_dest_q == ra_id)          fwd_a = out_alu_result_q;
      else if (fwd_wb_valid && fwd_wb_dest == ra_id)  fwd_a = fwd_wb_data;
    end
    fwd_b = rb_data;
    if (use_reg_b && rb_id != '0) begin
      if (own_ok && out_reg_dest_q == rb_id)          fwd_b = out_alu_result_q;
      else if (fwd_wb_valid && fwd_wb_dest == rb_id)  fwd_b = fwd_wb_data;
    end
    op_a        = fwd_a;
    op_b        = ex_reg_b ? fwd_b : offset_data;
    fast_target = next_pc + VIRTUAL_ADDR_WIDTH'(offset_data);
  end

  always_comb begin
    case (ex_alu_op)
      OP_ADD:  alu_result = op_a + op_b;
      OP_SUB:  alu_result = op_a - op_b;
      OP_AND:  alu_result = op_a & op_b;
      OP_OR:   alu_result = op_a | op_b;
      OP_XOR:  alu_result = op_a ^ op_b;
      OP_SLL:  alu_result = op_a << op_b[SHW-1:0];
      OP_SRL:  alu_result = op_a >> op_b[SHW-1:0];
      default: alu_result = '0;
    endcase
    mul_result = pend_a_q * pend_b_q;
  end

  // FSM: state register
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) state_q <= ST_IDLE;
    else        state_q <= state_d;
  end

  // FSM: output / strobe decode
  always_comb begin
    out_free  = !out_valid_q || out_ready;
    in_ready  = (state_q == ST_IDLE) && out_free;
    accept    = in_valid && in_ready && !flush;
    start_mul = accept && (ex_alu_op == OP_MUL);
    load_fast = accept && (ex_alu_op != OP_MUL);
    load_mul  = (state_q == ST_MUL_BUSY) && (cnt_q == CNTW'(1)) && out_free && !flush;
  end

  // FSM: next state
  always_comb begin
    state_d = state_q;
    case (state_q)
      ST_IDLE:     if (start_mul) state_d = ST_MUL_BUSY;
      ST_MUL_BUSY: if (load_mul)  state_d = ST_IDLE;
      default:     state_d = ST_IDLE;
    endcase
    if (flush) state_d = ST_IDLE;
  end

  // Datapath next-state
  always_comb begin
    out_valid_d         = out_valid_q;
    out_alu_result_d    = out_alu_result_q;
    out_store_data_d    = out_store_data_q;
    out_branch_target_d = out_branch_target_q;
    out_branch_taken_d  = out_branch_taken_q;
    out_reg_dest_d      = out_reg_dest_q;
    out_mem_to_reg_d    = out_mem_to_reg_q;
    out_reg_write_d     = out_reg_write_q;
    out_mem_write_d     = out_mem_write_q;
    out_mem_read_d      = out_mem_read_q;
    pend_a_d            = pend_a_q;
    pend_b_d            = pend_b_q;
    pend_store_d        = pend_store_q;
    pend_target_d       = pend_target_q;
    pend_dest_d         = pend_dest_q;
    pend_mem_to_reg_d   = pend_mem_to_reg_q;
    pend_reg_write_d    = pend_reg_write_q;
    pend_branch_d       = pend_branch_q;
    pend_mem_write_d    = pend_mem_write_q;
    pend_mem_read_d     = pend_mem_read_q;
    cnt_d               = cnt_q;

    if (out_valid_q && out_ready) out_valid_d = 1'b0;

    if (load_fast) begin
      out_valid_d         = 1'b1;
      out_alu_result_d    = alu_result;
      out_store_data_d    = fwd_b;
      out_branch_target_d = fast_target;
      out_branch_taken_d  = cm_branch && (alu_result == '0);
      out_reg_dest_d      = reg_dest;
      out_mem_to_reg_d    = wb_mem_to_reg;
      out_reg_write_d     = wb_reg_write;
      out_mem_write_d     = cm_mem_write;
      out_mem_read_d      = cm_mem_read;
    end else if (load_mul) begin
      out_valid_d         = 1'b1;
      out_alu_result_d    = mul_result;
      out_store_data_d    = pend_store_q;
      out_branch_target_d = pend_target_q;
      out_branch_taken_d  = pend_branch_q && (mul_result == '0);
      out_reg_dest_d      = pend_dest_q;
      out_mem_to_reg_d    = pend_mem_to_reg_q;
      out_reg_write_d     = pend_reg_write_q;
      out_mem_write_d     = pend_mem_write_q;
      out_mem_read_d      = pend_mem_read_q;
    end

    if (start_mul) begin
      pend_a_d          = op_a;
      pend_b_d          = op_b;
      pend_store_d      = fwd_b;
      pend_target_d     = fast_target;
      pend_dest_d       = reg_dest;
      pend_mem_to_reg_d = wb_mem_to_reg;
      pend_reg_write_d  = wb_reg_write;
      pend_branch_d     = cm_branch;
      pend_mem_write_d  = cm_mem_write;
      pend_mem_read_d   = cm_mem_read;
      cnt_d             = CNTW'(MUL_LATENCY - 1);
    end else if (load_mul) begin
      cnt_d = '0;
    end else if (state_q == ST_MUL_BUSY && cnt_q > CNTW'(1)) begin
      cnt_d = cnt_q - CNTW'(1);
    end

    if (flush) begin
      out_valid_d = 1'b0;
      cnt_d       = '0;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      out_valid_q         <= 1'b0;
      out_alu_result_q    <= '0;
      out_store_data_q    <= '0;
      out_branch_target_q <= '0;
      out_branch_taken_q  <= 1'b0;
      out_reg_dest_q      <= '0;
      out_mem_to_reg_q    <= 1'b0;
      out_reg_write_q     <= 1'b0;
      out_mem_write_q     <= 1'b0;
      out_mem_read_q      <= 1'b0;
      pend_a_q            <= '0;
      pend_b_q            <= '0;
      pend_store_q        <= '0;
      pend_target_q       <= '0;
      pend_dest_q         <= '0;
      pend_mem_to_reg_q   <= 1'b0;
      pend_reg_write_q    <= 1'b0;
      pend_branch_q       <= 1'b0;
      pend_mem_write_q    <= 1'b0;
      pend_mem_read_q     <= 1'b0;
      cnt_q               <= '0;
    end else begin
      out_valid_q         <= out_valid_d;
      out_alu_result_q    <= out_alu_result_d;
      out_store_data_q    <= out_store_data_d;
      out_branch_target_q <= out_branch_target_d;
      out_branch_taken_q  <= out_branch_taken_d;
      out_reg_dest_q      <= out_reg_dest_d;
      out_mem_to_reg_q    <= out_mem_to_reg_d;
      out_reg_write_q     <= out_reg_write_d;
      out_mem_write_q     <= out_mem_write_d;
      out_mem_read_q      <= out_mem_read_d;
      pend_a_q            <= pend_a_d;
      pend_b_q            <= pend_b_d;
      pend_store_q        <= pend_store_d;
      pend_target_q       <= pend_target_d;
      pend_dest_q         <= pend_dest_d;
      pend_mem_to_reg_q   <= pend_mem_to_reg_d;
      pend_reg_write_q    <= pend_reg_write_d;
      pend_branch_q       <= pend_branch_d;
      pend_mem_write_q    <= pend_mem_write_d;
      pend_mem_read_q     <= pend_mem_read_d;
      cnt_q               <= cnt_d;
    end
  end

  assign out_valid         = out_valid_q;
  assign out_alu_result    = out_alu_result_q;
  assign out_store_data    = out_store_data_q;
  assign out_branch_target = out_branch_target_q;
  assign out_branch_taken  = out_branch_taken_q;
  assign out_reg_dest      = out_reg_dest_q;
  assign out_mem_to_reg    = out_mem_to_reg_q;
  assign out_reg_write     = out_reg_write_q;
  assign out_mem_write     = out_mem_write_q;
  assign out_mem_read      = out_mem_read_q;

endmodule

// File: tb/tb_cpu_execute_stage.sv
// Directed bench for cpu_execute_stage with hand-computed expected values.
module tb_cpu_execute_stage;

  logic        clk = 1'b0;
  logic        rst_n, flush, in_valid, in_ready;
  logic        wb_mem_to_reg, wb_reg_write, cm_branch, cm_mem_write, cm_mem_read;
  logic [2:0]  ex_alu_op;
  logic        ex_reg_b;
  logic [31:0] next_pc, ra_data, rb_data, offset_data;
  logic [4:0]  ra_id, rb_id, reg_dest;
  logic        use_reg_b, fwd_wb_valid;
  logic [4:0]  fwd_wb_dest;
  logic [31:0] fwd_wb_data;
  logic        out_valid, out_ready;
  logic [31:0] out_alu_result, out_store_data, out_branch_target;
  logic        out_branch_taken;
  logic [4:0]  out_reg_dest;
  logic        out_mem_to_reg, out_reg_write, out_mem_write, out_mem_read;

  int unsigned checks = 0;
  int unsigned errors = 0;

  cpu_execute_stage #(
    .REG_WIDTH(32), .VIRTUAL_ADDR_WIDTH(32), .NUM_REGS(32),
    .NUM_ALU_OPS(8), .MUL_LATENCY(4)
  ) dut (
    .clk(clk), .rst_n(rst_n), .flush(flush),
    .in_valid(in_valid), .in_ready(in_ready),
    .wb_mem_to_reg(wb_mem_to_reg), .wb_reg_write(wb_reg_write),
    .cm_branch(cm_branch), .cm_mem_write(cm_mem_write), .cm_mem_read(cm_mem_read),
    .ex_alu_op(ex_alu_op), .ex_reg_b(ex_reg_b), .next_pc(next_pc),
    .ra_data(ra_data), .rb_data(rb_data), .offset_data(offset_data),
    .ra_id(ra_id), .rb_id(rb_id), .reg_dest(reg_dest), .use_reg_b(use_reg_b),
    .fwd_wb_valid(fwd_wb_valid), .fwd_wb_dest(fwd_wb_dest), .fwd_wb_data(fwd_wb_data),
    .out_valid(out_valid), .out_ready(out_ready),
    .out_alu_result(out_alu_result), .out_store_data(out_store_data),
    .out_branch_target(out_branch_target), .out_branch_taken(out_branch_taken),
    .out_reg_dest(out_reg_dest), .out_mem_to_reg(out_mem_to_reg),
    .out_reg_write(out_reg_write), .out_mem_write(out_mem_write),
    .out_mem_read(out_mem_read)
  );

  always #5 clk = ~clk;

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic idle_inputs();
    flush = 0; in_valid = 0; wb_mem_to_reg = 0; wb_reg_write = 0;
    cm_branch = 0; cm_mem_write = 0; cm_mem_read = 0; ex_alu_op = 0;
    ex_reg_b = 0; next_pc = 0; ra_data = 0; rb_data = 0; offset_data = 0;
    ra_id = 0; rb_id = 0; reg_dest = 0; use_reg_b = 0;
    fwd_wb_valid = 0; fwd_wb_dest = 0; fwd_wb_data = 0;
  endtask

  task automatic issue(input logic [2:0] op, input logic [4:0] raid, input logic [31:0] ra,
                       input logic [4:0] rbid, input logic [31:0] rb, input logic exb,
                       input logic useb, input logic [31:0] off, input logic [4:0] dest,
                       input logic rw, input logic br);
    in_valid = 1; ex_alu_op = op; ra_id = raid; ra_data = ra; rb_id = rbid; rb_data = rb;
    ex_reg_b = exb; use_reg_b = useb; offset_data = off; reg_dest = dest;
    wb_reg_write = rw; cm_branch = br;
  endtask

  logic [2:0]  t_op  [6] = '{3'd2, 3'd3, 3'd4, 3'd5, 3'd6, 3'd1};
  logic [31:0] t_a   [6] = '{32'hFF00FF00, 32'hFF00FF00, 32'hFF00FF00, 32'h00000001, 32'h80000000, 32'h0};
  logic [31:0] t_b   [6] = '{32'h0FF00FF0, 32'h0FF00FF0, 32'h0FF00FF0, 32'h0000003F, 32'h00000024, 32'h1};
  logic [31:0] t_exp [6] = '{32'h0F000F00, 32'hFFF0FFF0, 32'hF0F0F0F0, 32'h80000000, 32'h08000000, 32'hFFFFFFFF};

  initial begin
    idle_inputs();
    rst_n = 0; out_ready = 1;
    repeat (2) @(posedge clk);
    #1;
    chk("rst_out_valid", out_valid, 0);
    chk("rst_in_ready", in_ready, 1);
    chk("rst_result", out_alu_result, 0);
    chk("rst_dest", out_reg_dest, 0);
    rst_n = 1;
    tick();

    // ADD 5 + 7
    issue(3'd0, 5'd1, 32'd5, 5'd0, 32'd0, 0, 0, 32'd7, 5'd2, 1, 0);
    #1 chk("add_in_ready", in_ready, 1);
    tick(); in_valid = 0;
    chk("add_valid", out_valid, 1);
    chk("add_result", out_alu_result, 12);
    chk("add_reg_write", out_reg_write, 1);
    chk("add_dest", out_reg_dest, 2);
    tick();
    chk("add_pop", out_valid, 0);

    // Back-to-back with own-register forward
    issue(3'd0, 5'd6, 32'd1, 5'd7, 32'd2, 1, 1, 32'd0, 5'd3, 1, 0);
    tick();
    chk("b2b_first", out_alu_result, 3);
    chk("b2b_first_taken", out_branch_taken, 0);
    issue(3'd1, 5'd3, 32'd99, 5'd0, 32'd0, 0, 0, 32'd3, 5'd4, 1, 1);
    next_pc = 32'h100;
    #1 chk("b2b_in_ready", in_ready, 1);
    tick(); in_valid = 0; cm_branch = 0;
    chk("b2b_valid", out_valid, 1);
    chk("b2b_fwd_result", out_alu_result, 0);
    chk("b2b_taken", out_branch_taken, 1);
    chk("b2b_target", out_branch_target, 32'h103);
    chk("b2b_dest", out_reg_dest, 4);
    tick();

    // Remaining single-cycle ops back to back
    for (int i = 0; i < 6; i++) begin
      issue(t_op[i], 5'd0, t_a[i], 5'd0, 32'd0, 0, 0, t_b[i], 5'd1, 0, 0);
      tick();
      chk($sformatf("alu_op%0d", t_op[i]), out_alu_result, t_exp[i]);
    end
    in_valid = 0;
    tick();

    // Writeback forwarding on rb
    fwd_wb_valid = 1; fwd_wb_dest = 5'd5; fwd_wb_data = 32'h10;
    issue(3'd0, 5'd0, 32'h20, 5'd5, 32'h77, 0, 1, 32'd0, 5'd8, 0, 0);
    tick();
    chk("wb_fwd_store", out_store_data, 32'h10);
    chk("wb_fwd_result", out_alu_result, 32'h20);
    use_reg_b = 0;
    tick();
    chk("wb_nouse_store", out_store_data, 32'h77);
    fwd_wb_dest = 5'd0; ra_id = 0; rb_id = 0; rb_data = 32'h33; use_reg_b = 1; ex_reg_b = 1;
    tick();
    chk("wb_id0_store", out_store_data, 32'h33);
    chk("wb_id0_result", out_alu_result, 32'h53);
    in_valid = 0; fwd_wb_valid = 0;
    tick();

    // MUL 0xFFFF_FFFF * 2
    issue(3'd7, 5'd9, 32'hFFFFFFFF, 5'd0, 32'd0, 0, 0, 32'd2, 5'd10, 1, 0);
    #1 chk("mul_in_ready", in_ready, 1);
    tick(); in_valid = 0;
    chk("mul_c0_valid", out_valid, 0);
    chk("mul_c0_ready", in_ready, 0);
    tick();
    chk("mul_c1_valid", out_valid, 0);
    chk("mul_c1_ready", in_ready, 0);
    tick();
    chk("mul_c2_valid", out_valid, 0);
    chk("mul_c2_ready", in_ready, 0);
    tick();
    chk("mul_c3_valid", out_valid, 1);
    chk("mul_result", out_alu_result, 32'hFFFFFFFE);
    chk("mul_dest", out_reg_dest, 10);
    chk("mul_done_ready", in_ready, 1);
    tick();

    // Output stall for 3 cycles
    out_ready = 0;
    issue(3'd0, 5'd0, 32'd10, 5'd0, 32'd0, 0, 0, 32'd1, 5'd11, 0, 0);
    tick();
    chk("stall_first", out_alu_result, 11);
    issue(3'd0, 5'd0, 32'd20, 5'd0, 32'd0, 0, 0, 32'd2, 5'd12, 0, 0);
    #1 chk("stall_in_ready", in_ready, 0);
    for (int i = 0; i < 3; i++) begin
      tick();
      chk("stall_valid", out_valid, 1);
      chk("stall_result", out_alu_result, 11);
      chk("stall_dest", out_reg_dest, 11);
      chk("stall_ready", in_ready, 0);
    end
    out_ready = 1;
    #1 chk("release_ready", in_ready, 1);
    tick(); in_valid = 0;
    chk("release_valid", out_valid, 1);
    chk("release_result", out_alu_result, 22);
    chk("release_dest", out_reg_dest, 12);
    tick();
    chk("release_pop", out_valid, 0);

    // Flush during MUL_BUSY
    issue(3'd7, 5'd0, 32'd3, 5'd0, 32'd0, 0, 0, 32'd4, 5'd12, 1, 0);
    tick(); in_valid = 0;
    tick();
    flush = 1;
    tick(); flush = 0;
    chk("flush_mul_valid", out_valid, 0);
    chk("flush_mul_ready", in_ready, 1);
    tick(); tick();
    chk("flush_mul_late", out_valid, 0);

    // Flush coincident with out_ready and a new input
    issue(3'd0, 5'd0, 32'd3, 5'd0, 32'd0, 0, 0, 32'd4, 5'd13, 1, 0);
    tick();
    chk("flush_pre_result", out_alu_result, 7);
    issue(3'd0, 5'd0, 32'd50, 5'd0, 32'd0, 0, 0, 32'd1, 5'd14, 1, 0);
    flush = 1;
    tick(); flush = 0; in_valid = 0;
    chk("flush_out_valid", out_valid, 0);
    chk("flush_no_accept", out_alu_result, 7);
    chk("flush_dest_held", out_reg_dest, 13);
    tick();
    chk("flush_late_valid", out_valid, 0);

    // Reset mid-MUL
    issue(3'd7, 5'd0, 32'd5, 5'd0, 32'd0, 0, 0, 32'd6, 5'd15, 1, 0);
    tick(); in_valid = 0;
    tick();
    rst_n = 0;
    #1;
    chk("rstm_valid", out_valid, 0);
    chk("rstm_result", out_alu_result, 0);
    chk("rstm_dest", out_reg_dest, 0);
    chk("rstm_reg_write", out_reg_write, 0);
    chk("rstm_ready", in_ready, 1);
    tick(); rst_n = 1;
    repeat (4) tick();
    chk("rstm_late_valid", out_valid, 0);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
